// File: rtl/cv32e40p_x_copro_pkg.sv
// Shared types for the custom-0 coprocessor adapter: opcode, ALU ops, queue entry, FSM states.
package cv32e40p_x_copro_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADD3 = 3'b011
  } alu_op_e;

  typedef struct packed {
    logic [3:0]       id;
    logic [4:0]       rd;
    alu_op_e          funct3;
    logic [2:0][31:0] rs;
    logic             committed;
    logic             killed;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/cv32e40p_x_copro_adapter_if.sv
// Issue/commit/result bundle between the core's offload dispatcher (master) and the adapter (slave).
interface cv32e40p_x_copro_adapter_if;
  logic             x_issue_valid_i;
  logic             x_issue_ready_o;
  logic [31:0]      x_issue_req_instr_i;
  logic [3:0]       x_issue_req_id_i;
  logic [2:0][31:0] x_issue_req_rs_i;
  logic [2:0]       x_issue_req_rs_valid_i;
  logic             x_issue_resp_accept_o;
  logic             x_issue_resp_writeback_o;
  logic             x_issue_resp_loadstore_o;
  logic             x_commit_valid_i;
  logic [3:0]       x_commit_id_i;
  logic             x_commit_kill_i;
  logic             x_result_valid_o;
  logic             x_result_ready_i;
  logic [3:0]       x_result_id_o;
  logic [31:0]      x_result_data_o;
  logic [4:0]       x_result_rd_o;
  logic             x_result_we_o;

  modport slave (
    input  x_issue_valid_i, x_issue_req_instr_i, x_issue_req_id_i, x_issue_req_rs_i,
           x_issue_req_rs_valid_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
           x_result_ready_i,
    output x_issue_ready_o, x_issue_resp_accept_o, x_issue_resp_writeback_o,
           x_issue_resp_loadstore_o, x_result_valid_o, x_result_id_o, x_result_data_o,
           x_result_rd_o, x_result_we_o
  );

  modport master (
    output x_issue_valid_i, x_issue_req_instr_i, x_issue_req_id_i, x_issue_req_rs_i,
           x_issue_req_rs_valid_i, x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
           x_result_ready_i,
    input  x_issue_ready_o, x_issue_resp_accept_o, x_issue_resp_writeback_o,
           x_issue_resp_loadstore_o, x_result_valid_o, x_result_id_o, x_result_data_o,
           x_result_rd_o, x_result_we_o
  );
endinterface

// File: rtl/cv32e40p_x_copro_alu.sv
// Combinational integer ALU for the custom-0 ops; arithmetic wraps modulo 2^32.
module cv32e40p_x_copro_alu
  import cv32e40p_x_copro_pkg::*;
(
  input  alu_op_e          op_i,
  input  logic [2:0][31:0] rs_i,
  output logic [31:0]      result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = rs_i[0] + rs_i[1];
      OP_SUB:  result_o = rs_i[0] - rs_i[1];
      OP_XOR:  result_o = rs_i[0] ^ rs_i[1];
      OP_ADD3: result_o = rs_i[0] + rs_i[1] + rs_i[2];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cv32e40p_x_copro_adapter.sv
// XIF coprocessor endpoint: decodes custom-0, queues accepted instructions, applies commit/kill
// by id, executes committed ones in order with a fixed latency and returns each result.
module cv32e40p_x_copro_adapter
  import cv32e40p_x_copro_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  cv32e40p_x_copro_adapter_if.slave  xif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef logic [PTR_W:0] ptr_t;

  entry_t             entries_q [DEPTH];
  entry_t             entries_d [DEPTH];
  ptr_t               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ptr_t               count;
  logic [DEPTH-1:0]   slot_vld;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         res_id_q, res_id_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [4:0]         res_rd_q, res_rd_d;
  logic               res_we_q, res_we_d;

  logic [31:0]        instr;
  logic               supported, need_rs3, ops_ok, full, push, pop, head_vld;
  entry_t             new_entry, head;
  logic [31:0]        alu_result;
  logic               unused_instr;

  assign instr        = xif.x_issue_req_instr_i;
  assign unused_instr = ^instr[24:15];

  assign supported = (instr[6:0] == OPCODE_CUSTOM0) && (instr[31:25] == 7'd0) && !instr[14];
  assign need_rs3  = (alu_op_e'(instr[14:12]) == OP_ADD3);
  assign ops_ok    = xif.x_issue_req_rs_valid_i[0] && xif.x_issue_req_rs_valid_i[1] &&
                     (!need_rs3 || xif.x_issue_req_rs_valid_i[2]);

  // Full is judged on registered pointers only, so a same-cycle pop never frees a slot early.
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign xif.x_issue_ready_o          = supported ? (!full && ops_ok) : 1'b1;
  assign push                         = xif.x_issue_valid_i && xif.x_issue_ready_o && supported;
  assign xif.x_issue_resp_accept_o    = push;
  assign xif.x_issue_resp_writeback_o = push;
  assign xif.x_issue_resp_loadstore_o = 1'b0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot_vld
    logic [PTR_W-1:0] off;
    assign off         = PTR_W'(g) - rd_ptr_q[PTR_W-1:0];
    assign slot_vld[g] = ({1'b0, off} < count);
  end

  assign head     = entries_q[rd_ptr_q[PTR_W-1:0]];
  assign head_vld = (count != '0);

  // A commit message arriving alongside the issue of the same id lands on the new entry.
  always_comb begin
    new_entry        = '0;
    new_entry.id     = xif.x_issue_req_id_i;
    new_entry.rd     = instr[11:7];
    new_entry.funct3 = alu_op_e'(instr[14:12]);
    new_entry.rs     = xif.x_issue_req_rs_i;
    if (xif.x_commit_valid_i && (xif.x_commit_id_i == xif.x_issue_req_id_i)) begin
      if (xif.x_commit_kill_i) new_entry.killed    = 1'b1;
      else                     new_entry.committed = 1'b1;
    end
  end

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (xif.x_commit_valid_i && slot_vld[i] && (entries_q[i].id == xif.x_commit_id_i)) begin
        if (xif.x_commit_kill_i) entries_d[i].killed    = 1'b1;
        else                     entries_d[i].committed = 1'b1;
      end
    end
    if (push) begin
      entries_d[wr_ptr_q[PTR_W-1:0]] = new_entry;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  cv32e40p_x_copro_alu u_alu (
    .op_i     (head.funct3),
    .rs_i     (head.rs),
    .result_o (alu_result)
  );

  // Kill flags are only consulted in IDLE, so a head already in EXEC/RESULT always completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_we_d   = res_we_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld && head.killed) begin
          pop = 1'b1;
        end else if (head_vld && head.committed) begin
          cnt_d   = CNT_W'(LATENCY);
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          res_id_d   = head.id;
          res_data_d = alu_result;
          res_rd_d   = head.rd;
          res_we_d   = (head.rd != 5'd0);
          state_d    = RESULT;
        end
      end
      RESULT: begin
        if (xif.x_result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_we_q   <= res_we_d;
      entries_q  <= entries_d;
    end
  end

  assign xif.x_result_valid_o = (state_q == RESULT);
  assign xif.x_result_id_o    = res_id_q;
  assign xif.x_result_data_o  = res_data_q;
  assign xif.x_result_rd_o    = res_rd_q;
  assign xif.x_result_we_o    = res_we_q;

endmodule

// File: doc/cv32e40p_x_copro_adapter.md
# cv32e40p_x_copro_adapter

Coprocessor-side endpoint of the CORE-V-XIF issue, commit and result interfaces, sitting opposite the core's offload dispatcher. It decodes offered custom-0 instructions and accepts or rejects them, queues up to DEPTH accepted instructions with their operands, and applies commit/kill by id. Committed instructions execute in order through a small integer ALU with a fixed latency, and each result is returned to the core over a valid/ready result handshake.

## Interface
- DEPTH, 4: in-flight queue entries; power of 2, 2..8.
- LATENCY, 1: execute cycles per instruction; ≥1.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- x_issue_valid_i  in  1  issue request offered.
- x_issue_ready_o  out  1  issue handshake ready.
- x_issue_req_instr_i  in  32  instruction word.
- x_issue_req_id_i  in  4  instruction id.
- x_issue_req_rs_i  in  3x32  source operands rs1..rs3.
- x_issue_req_rs_valid_i  in  3  operand valid flags.
- x_issue_resp_accept_o  out  1  instruction accepted.
- x_issue_resp_writeback_o  out  1  will write rd.
- x_issue_resp_loadstore_o  out  1  tied 0.
- x_commit_valid_i  in  1  commit message valid.
- x_commit_id_i  in  4  id being committed or killed.
- x_commit_kill_i  in  1  1 = kill, 0 = commit.
- x_result_valid_o  out  1  result offered.
- x_result_ready_i  in  1  core accepts result.
- x_result_id_o  out  4  result id.
- x_result_data_o  out  32  result value.
- x_result_rd_o  out  5  destination register.
- x_result_we_o  out  1  write enable; equals (rd != 0).

## Operation
- Decode: opcode 7'b0001011 and funct7 0 are supported. funct3 000 = rs1+rs2, 001 = rs1-rs2, 010 = rs1^rs2, 011 = rs1+rs2+rs3. Anything else is unsupported.
- Operands needed: rs1 and rs2 always; rs3 only for funct3 011.
- x_issue_ready_o is combinational:
  - supported instruction: ~full & all needed rs_valid.
  - unsupported instruction: 1, so it is rejected in one handshake.
- Issue response is valid only during the handshake cycle:
  - accept = supported; writeback = supported; loadstore = 0.
- An accepted handshake pushes an entry {id, rd, funct3, rs1..rs3, committed=0, killed=0}.
- Commit message: every valid queued entry whose id matches sets committed (kill=0) or killed (kill=1).
  - It also applies to an entry pushed in the same cycle with the matching id (bypass).
  - A message for an id not present is ignored.
- FSM state IDLE:
  - head valid & killed: pop the head, stay in IDLE (one kill drained per cycle).
  - head valid & committed & ~killed: load cnt=LATENCY, go to EXEC.
  - otherwise: stay in IDLE.
- FSM state EXEC: decrement cnt; at cnt==1 latch the ALU result into the result registers and go to RESULT.
- FSM state RESULT:
  - x_result_valid_o=1; id/data/rd/we are held stable until ready.
  - On ready, pop the head and go to IDLE.
- A kill received for the head while it is in EXEC/RESULT is ignored; committed instructions always complete.
- Arithmetic is modulo 2^32; no flags.

## Timing
- Reset values: state=IDLE, queue empty, pointers 0, cnt 0.
  - x_result_valid_o=0; x_result_id/data/rd/we_o=0.
  - x_issue_resp_* = 0 unless a handshake is in progress.
- Latency: issue+commit in cycle T with the queue empty gives x_result_valid_o in T+2+LATENCY.
- Back-to-back throughput is one result per LATENCY+2 cycles (RESULT→IDLE→EXEC).
- Pointers are log2(DEPTH)+1 bits; full = MSBs differ and low bits equal.
  - While full, ready is 0 for supported instructions even if a pop occurs that cycle.
- Push and pop in the same cycle are both honored.
- The 4-bit id is opaque: wrap-around is ignored and no uniqueness check is made.
- Reset asserted mid-operation discards all entries and any pending result in the next cycle; no result is emitted.

## Structure
- Shared package cv32e40p_x_copro_pkg holds:
  - the OPCODE_CUSTOM0 constant;
  - the funct3 op enum;
  - the queue entry struct;
  - the FSM state enum {IDLE, EXEC, RESULT}.
- One sub-module, cv32e40p_x_copro_alu: combinational funct3/rs1..rs3 → 32-bit result. The queue and FSM live in the top.

## Test plan
- Issue ADD rs1=5, rs2=7, id=3, committed the same cycle, LATENCY=1, result_ready=1 → result_valid at T+3 with id=3, data=12, rd as encoded, we=1.
- Issue funct3=111 → ready=1, accept=0, writeback=0, no entry; a later result count of 0.
- SUB with rs2_valid=0 for 3 cycles → ready=0 for 3 cycles, handshake on cycle 4; 1−2 → 32'hFFFF_FFFF.
- Fill DEPTH=4 uncommitted entries (ids 0–3) → ready=0 on the 5th issue. Then kill id 1 and commit ids 0, 2, 3 → results with ids 0, 2, 3 in order, none for id 1.
- Hold result_ready=0 for 5 cycles → result_valid stays 1 with stable id/data; popped on the first ready cycle.
- Assert rst_ni=0 during EXEC with 2 entries queued → the next cycle shows an empty queue and result_valid=0; no result after release.
